// File: rtl/s420_param_match_counter.sv
// Enable-gated up/down counter with synchronous load, wrap/saturate limits,
// a registered mask-match pulse and a saturating match tally.
module s420_param_match_counter #(
  parameter int WIDTH  = 16,
  parameter int MASK_W = 17,
  parameter int WRAP   = 1,
  parameter int HIT_W  = 8
) (
  input  logic              blif_clk_net,
  input  logic              blif_reset_net,
  input  logic              en,
  input  logic              dir,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [MASK_W-1:0] c,
  input  logic              hit_clr,
  output logic [WIDTH-1:0]  count,
  output logic              z,
  output logic              tc,
  output logic [HIT_W-1:0]  hit_cnt
);

  localparam logic [WIDTH-1:0]  CNT_MAX   = '1;
  localparam logic [HIT_W-1:0]  HIT_MAX   = '1;
  localparam longint unsigned   CNT_RANGE = 64'd1 << WIDTH;

  logic [WIDTH-1:0] count_q, count_d;
  logic             z_q, z_d;
  logic             tc_q, tc_d;
  logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             mask_bit;
  logic             hit;

  // Mask bits beyond the counter range are skipped so a truncated compare
  // can never alias them onto a reachable count.
  always_comb begin
    mask_bit = 1'b0;
    for (int k = 0; k < MASK_W; k++) begin
      if ((64'(k) < CNT_RANGE) && (count_q == WIDTH'(k))) mask_bit = c[k];
    end
  end

  assign hit = en & ~load & mask_bit;

  always_comb begin
    count_d = count_q;
    z_d     = 1'b0;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_val;
    end else begin
      z_d = hit;
      if (en) begin
        if (!dir) begin
          if (count_q == CNT_MAX) begin
            tc_d    = 1'b1;
            count_d = (WRAP != 0) ? '0 : CNT_MAX;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          if (count_q == '0) begin
            tc_d    = 1'b1;
            count_d = (WRAP != 0) ? CNT_MAX : '0;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (hit_clr)                         hit_cnt_d = '0;
    else if (hit && hit_cnt_q != HIT_MAX) hit_cnt_d = hit_cnt_q + 1'b1;
  end

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      count_q   <= '0;
      z_q       <= 1'b0;
      tc_q      <= 1'b0;
      hit_cnt_q <= '0;
    end else begin
      count_q   <= count_d;
      z_q       <= z_d;
      tc_q      <= tc_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign count   = count_q;
  assign z       = z_q;
  assign tc      = tc_q;
  assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_s420_param_match_counter.sv
// Three configurations (16-bit wrap, 4-bit wrap, 4-bit saturate) share one
// stimulus stream; a behavioural model feeds a scoreboard queue per edge.
module tb_s420_param_match_counter;

  logic        clk = 1'b0;
  logic        rst, en, dir, load, hit_clr;
  logic [15:0] lv16;
  logic [3:0]  lv4;
  logic [16:0] cm;

  logic [15:0] count_a;  logic z_a, tc_a;  logic [7:0] hc_a;
  logic [3:0]  count_w;  logic z_w, tc_w;  logic [1:0] hc_w;
  logic [3:0]  count_s;  logic z_s, tc_s;  logic [1:0] hc_s;

  always #5 clk = ~clk;

  s420_param_match_counter #(.WIDTH(16), .MASK_W(17), .WRAP(1), .HIT_W(8)) dut_a (
    .blif_clk_net(clk), .blif_reset_net(rst), .en(en), .dir(dir), .load(load),
    .load_val(lv16), .c(cm), .hit_clr(hit_clr),
    .count(count_a), .z(z_a), .tc(tc_a), .hit_cnt(hc_a));

  s420_param_match_counter #(.WIDTH(4), .MASK_W(17), .WRAP(1), .HIT_W(2)) dut_w (
    .blif_clk_net(clk), .blif_reset_net(rst), .en(en), .dir(dir), .load(load),
    .load_val(lv4), .c(cm), .hit_clr(hit_clr),
    .count(count_w), .z(z_w), .tc(tc_w), .hit_cnt(hc_w));

  s420_param_match_counter #(.WIDTH(4), .MASK_W(17), .WRAP(0), .HIT_W(2)) dut_s (
    .blif_clk_net(clk), .blif_reset_net(rst), .en(en), .dir(dir), .load(load),
    .load_val(lv4), .c(cm), .hit_clr(hit_clr),
    .count(count_s), .z(z_s), .tc(tc_s), .hit_cnt(hc_s));

  typedef struct {
    int cnt;
    bit z;
    bit tc;
    int hc;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // model state, index 0=a, 1=w, 2=s
  int m_cnt [3];
  bit m_z   [3];
  bit m_tc  [3];
  int m_hc  [3];

  task automatic model(input int i, input int w, input bit wrap, input int hw, input int lv);
    int maxv, hmax;
    bit h;
    maxv = (1 << w) - 1;
    hmax = (1 << hw) - 1;
    if (rst) begin
      m_cnt[i] = 0; m_z[i] = 0; m_tc[i] = 0; m_hc[i] = 0;
      return;
    end
    h = (m_cnt[i] < 17) ? cm[m_cnt[i]] : 1'b0;
    h = h && en && !load;
    if (hit_clr)               m_hc[i] = 0;
    else if (h && m_hc[i] < hmax) m_hc[i] = m_hc[i] + 1;
    m_tc[i] = 0;
    if (load) begin
      m_cnt[i] = lv & maxv;
      m_z[i]   = 0;
    end else begin
      m_z[i] = h;
      if (en && !dir) begin
        if (m_cnt[i] == maxv) begin m_tc[i] = 1; m_cnt[i] = wrap ? 0 : maxv; end
        else m_cnt[i] = m_cnt[i] + 1;
      end else if (en && dir) begin
        if (m_cnt[i] == 0) begin m_tc[i] = 1; m_cnt[i] = wrap ? maxv : 0; end
        else m_cnt[i] = m_cnt[i] - 1;
      end
    end
  endtask

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit d, input bit l,
                      input int lv, input logic [16:0] m, input bit hcl);
    exp_t ex;
    rst = r; en = e; dir = d; load = l; cm = m; hit_clr = hcl;
    lv16 = lv[15:0]; lv4 = lv[3:0];
    model(0, 16, 1'b1, 8, lv);
    model(1, 4,  1'b1, 2, lv);
    model(2, 4,  1'b0, 2, lv);
    for (int i = 0; i < 3; i++) begin
      ex.cnt = m_cnt[i]; ex.z = m_z[i]; ex.tc = m_tc[i]; ex.hc = m_hc[i];
      sb_q.push_back(ex);
    end
    @(posedge clk);
    #1;
    ex = sb_q.pop_front();
    check("a.count", int'(count_a), ex.cnt); check("a.z", int'(z_a), int'(ex.z));
    check("a.tc", int'(tc_a), int'(ex.tc));  check("a.hit_cnt", int'(hc_a), ex.hc);
    ex = sb_q.pop_front();
    check("w.count", int'(count_w), ex.cnt); check("w.z", int'(z_w), int'(ex.z));
    check("w.tc", int'(tc_w), int'(ex.tc));  check("w.hit_cnt", int'(hc_w), ex.hc);
    ex = sb_q.pop_front();
    check("s.count", int'(count_s), ex.cnt); check("s.z", int'(z_s), int'(ex.z));
    check("s.tc", int'(tc_s), int'(ex.tc));  check("s.hit_cnt", int'(hc_s), ex.hc);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_z[i] = 0; m_tc[i] = 0; m_hc[i] = 0; end
    rst = 1; en = 1; dir = 0; load = 0; hit_clr = 0; lv16 = '0; lv4 = '0; cm = '0;

    // reset held two cycles with en=1
    step(1, 1, 0, 0, 0, 17'h0, 0);
    step(1, 1, 0, 0, 0, 17'h0, 0);
    check("rst.count_direct", int'(count_a), 0);

    // mask 0b101 counting up from 0: pulses after count 0 and 2
    for (int k = 0; k < 5; k++) step(0, 1, 0, 0, 0, 17'h00005, 0);
    check("match.hit_cnt_at4", int'(hc_a), 2);
    check("match.count_at5", int'(count_a), 5);

    // load 0xE, up through the wrap / saturation point
    step(0, 0, 0, 1, 'hE, 17'h0, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 17'h0, 0);
    check("wrap.w_count", int'(count_w), 1);
    check("sat.s_count", int'(count_s), 15);

    // saturate at max: held with tc every enabled edge
    step(0, 0, 0, 1, 'hF, 17'h0, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 17'h0, 0);
    check("sat.s_tc_held", int'(tc_s), 1);

    // down from 0: wrap to max / hold at 0
    step(0, 0, 1, 1, 0, 17'h0, 0);
    step(0, 1, 1, 0, 0, 17'h0, 0);
    check("down.a_wrap", int'(count_a), 16'hFFFF);
    check("down.w_tc", int'(tc_w), 1);
    step(0, 1, 1, 0, 0, 17'h0, 0);

    // load wins over en with a matching count; hit_clr wins over hit
    step(0, 1, 0, 1, 0, 17'h1FFFF, 0);
    step(0, 1, 0, 1, 3, 17'h1FFFF, 0);
    check("load.z_blocked", int'(z_a), 0);
    step(0, 1, 0, 0, 0, 17'h1FFFF, 1);
    check("clr.hit_cnt", int'(hc_a), 0);

    // tally saturation at 3 on the 2-bit instances
    step(0, 0, 0, 1, 0, 17'h1FFFF, 1);
    for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 0, 17'h1FFFF, 0);
    check("tally.w_sat", int'(hc_w), 3);
    check("tally.a_six", int'(hc_a), 6);

    // reset mid-run clears everything on the next edge
    step(1, 1, 0, 0, 0, 17'h1FFFF, 0);
    check("rst_mid.z", int'(z_a), 0);

    // randomised mix
    for (int k = 0; k < 200; k++)
      step(($urandom_range(0, 40) == 0), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) == 0, int'($urandom_range(0, 65535)),
           17'($urandom), $urandom_range(0, 15) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
